// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit segment display scanner with timed message overlay
// and background blink; characters come from an external word library.
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 100000,
    parameter int MSG_HOLD     = 250,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] mode_idx,
    input  logic       msg_req,
    input  logic [3:0] msg_idx,
    input  logic       blink_en,
    output logic [3:0] lib_index,
    input  logic [6:0] char0,
    input  logic [6:0] char1,
    input  logic [6:0] char2,
    input  logic [6:0] char3,
    output logic [6:0] seg_out,
    output logic [3:0] dig_sel,
    output logic       msg_busy,
    output logic       msg_ack
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (MSG_HOLD > 1) ? $clog2(MSG_HOLD + 1) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {
        SHOW,
        MSG
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic [1:0]      ptr_q;
    logic [HW-1:0]   hold_q;
    logic [3:0]      msg_q;
    logic            phase_q;
    logic [BW-1:0]   bcnt_q;
    logic [6:0]      seg_q;
    logic [3:0]      dig_q;
    logic            ack_q;

    logic            scan_tick;
    logic            frame_tick;
    logic            hold_last;
    logic            blank;
    logic [6:0]      ch_d;

    assign scan_tick  = (div_q == DW'(SCAN_DIV - 1));
    assign frame_tick = scan_tick && (ptr_q == 2'd3);
    assign hold_last  = (hold_q >= HW'(MSG_HOLD - 1));
    assign blank      = (state_q == SHOW) && blink_en && phase_q;

    assign lib_index = (state_q == MSG) ? msg_q : mode_idx;
    assign seg_out   = seg_q;
    assign dig_sel   = dig_q;
    assign msg_busy  = (state_q == MSG);
    assign msg_ack   = ack_q;

    always_comb begin
        ch_d = char0;
        case (ptr_q)
            2'd0:    ch_d = char0;
            2'd1:    ch_d = char1;
            2'd2:    ch_d = char2;
            default: ch_d = char3;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SHOW;
            div_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            msg_q   <= '0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
            seg_q   <= '0;
            dig_q   <= 4'b0001;
            ack_q   <= 1'b0;
        end else begin
            div_q <= scan_tick ? '0 : div_q + 1'b1;
            if (scan_tick) begin
                ptr_q <= ptr_q + 2'd1;
            end
            ack_q <= msg_req;

            // A new request always wins, even on the expiring frame.
            if (msg_req) begin
                state_q <= MSG;
                msg_q   <= msg_idx;
                hold_q  <= '0;
            end else if (state_q == MSG && frame_tick) begin
                if (hold_last) begin
                    hold_q  <= HW'(MSG_HOLD);
                    state_q <= SHOW;
                end else begin
                    hold_q <= hold_q + 1'b1;
                end
            end

            if (!blink_en) begin
                phase_q <= 1'b0;
                bcnt_q  <= '0;
            end else if (frame_tick) begin
                if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
                    bcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    bcnt_q <= bcnt_q + 1'b1;
                end
            end

            seg_q <= blank ? 7'd0 : ch_d;
            dig_q <= 4'b0001 << ptr_q;
        end
    end

endmodule
